bot_icon_gen: RTL and testbench
===============================

// Module: bot_icon_gen
// PURPOSE
//  Upstream neighbour of the colorizer: produces the 2-bit icon pixel code that marks the Rojobot position/heading.
//  Per display pixel: decide whether it falls in a 16x16 icon window centred on the bot. If so, look up an oriented
//  bitmap; otherwise return transparent 2'b00. Bot pose is latched once per frame to prevent tearing.
//  Output is pipelined; a delayed video_on is supplied so the colorizer sees aligned inputs.
// PARAMETERS
//  SCALE_SHIFT  2    world cell -> display pixels (128x128 world -> 512x512 display region)
//  ICON_SIZE    16   icon edge in display pixels (power of 2; window offset = ICON_SIZE/2)
//  WORLD_PIX    512  display extent of world region; pixels at row/col >= WORLD_PIX never show icon
// PORTS
//  clock        in   1   25 MHz pixel clock
//  rst          in   1   synchronous, active-high reset
//  frame_start  in   1   one-cycle pulse at start of vertical blanking; latches pose
//  video_on_in  in   1   active-video flag from timing generator
//  pixel_row    in   10  current display row
//  pixel_column in   10  current display column
//  loc_x        in   8   bot world X (0..127 used, bit7 ignored)
//  loc_y        in   8   bot world Y (0..127 used, bit7 ignored)
//  bot_info     in   8   [2:0] heading: 0=N,1=NE,2=E,3=SE,4=S,5=SW,6=W,7=NW; [7:3] ignored
//  icon         out  2   icon pixel code: 00 transparent, 01/10/11 icon colours 1/2/3
//  video_on_out out  1   video_on_in delayed to match icon latency
// BEHAVIOUR
//  Reset: icon=00, video_on_out=0, latched pose (x,y,heading)=0, all pipeline regs=0. Reset mid-frame flushes the
//   pipeline; outputs stay 00/0 until two valid cycles have passed after rst deasserts.
//  Pose latch: on frame_start=1 capture loc_x[6:0], loc_y[6:0], bot_info[2:0]. New pose applies to pixels
//   presented from the following cycle. loc/bot_info changes between pulses have no effect.
//  Window: X0 = (lx<<SCALE_SHIFT) - ICON_SIZE/2, Y0 likewise, computed as 11-bit signed (may be negative).
//   In-window iff X0<=col<X0+ICON_SIZE, Y0<=row<Y0+ICON_SIZE, col<WORLD_PIX, row<WORLD_PIX.
//   Local coords lc=col-X0, lr=row-Y0 (4 bits).
//  Orientation: ROM holds 2 base bitmaps: B0=N (cardinal), B1=NE (diagonal); base=heading[0], q=heading[2:1]
//   (clockwise quarter-turns). Source (sr,sc): q=0:(lr,lc); q=1:(15-lc,lr); q=2:(15-lr,15-lc); q=3:(lc,15-lr).
//  Pipeline, latency 2 cycles from pixel_row/column/video_on_in:
//   S1 reg: in_win, base, sr, sc, von1. S2 reg: icon = (in_win & von1) ? rom[base][sr][sc] : 00; video_on_out=von1.
//  video_on_in=0: icon forced 00 regardless of window.
//  Boundaries: lx=0 -> X0=-8, left half clipped. lx=127 -> X0=500, cols 512..515 suppressed.
//   frame_start coinciding with an active pixel: that pixel uses the old pose.
// STRUCTURE
//  Shared package rojobot_video_pkg: heading constants (HDG_N..HDG_NW), ICON_TRANSPARENT=2'b00,
//   ICON_SIZE, SCALE_SHIFT, WORLD_PIX defaults.
//  Sub-module icon_rom: combinational 2x16x16x2-bit bitmap table (base, sr, sc) -> code; registered in bot_icon_gen S2.
//  Top holds pose latch, window compare, coordinate rotation and pipeline.
// TESTING
//  1 Reset: assert rst with video active and bot in view -> icon=00, video_on_out=0 every cycle; after release
//    first non-zero icon appears no earlier than 2 cycles later.
//  2 Pose latch: frame_start with loc=(32,32), heading 0; then change loc to (100,100) without pulse -> icon only
//    at rows/cols 120..135; pixel (120,120) code = rom[0][0][0], 2 cycles after presenting it.
//  3 Rotation: heading 2 (E), pixel local (lr=3,lc=5) -> icon = rom[0][10][3]; heading 7 (NW), same pixel
//    -> rom[1][5][12].
//  4 Clipping: loc=(0,0) -> cols/rows 0..7 only carry icon; loc=(127,127) -> rows/cols 500..511 carry icon,
//    512..515 give 00.
//  5 Blanking: in-window pixel with video_on_in=0 -> icon=00, video_on_out=0 two cycles later.
//  6 Latch timing: frame_start on the same cycle as an in-window pixel with new pose elsewhere -> that pixel
//    still shows old-pose icon; next cycle uses new pose.

Source files
------------

// File: rtl/rojobot_video_pkg.sv
// Shared definitions for the Rojobot video path.
// Provides the heading encoding carried in bot_info[2:0], the transparent
// icon code, and default geometry values for the icon generator.
package rojobot_video_pkg;

   // Heading values in 45-degree steps, clockwise from north
   typedef enum logic [2:0] {
      HDG_N  = 3'd0,
      HDG_NE = 3'd1,
      HDG_E  = 3'd2,
      HDG_SE = 3'd3,
      HDG_S  = 3'd4,
      HDG_SW = 3'd5,
      HDG_W  = 3'd6,
      HDG_NW = 3'd7
   } heading_e;

   localparam logic [1:0] ICON_TRANSPARENT = 2'b00;

   // World cell -> display pixel scaling, icon edge and world display extent
   localparam int SCALE_SHIFT = 2;
   localparam int ICON_SIZE   = 16;
   localparam int WORLD_PIX   = 512;

endpackage

// File: rtl/bot_icon_gen_if.sv
// Pixel/pose bus between the video timing side and the bot icon generator.
//   frame_start   : one-cycle pulse at start of vertical blanking
//   video_on_in   : active-video flag
//   pixel_row/col : current display coordinate (10 bits each)
//   loc_x/loc_y   : bot world position (bit 7 ignored)
//   bot_info      : [2:0] heading
//   icon          : 2-bit icon pixel code returned by the generator
//   video_on_out  : video_on_in delayed to line up with icon
// master drives the pixel/pose inputs; slave is the icon generator.
interface bot_icon_gen_if;
   logic       frame_start;
   logic       video_on_in;
   logic [9:0] pixel_row;
   logic [9:0] pixel_column;
   logic [7:0] loc_x;
   logic [7:0] loc_y;
   logic [7:0] bot_info;
   logic [1:0] icon;
   logic       video_on_out;

   modport master (
      output frame_start, video_on_in, pixel_row, pixel_column,
             loc_x, loc_y, bot_info,
      input  icon, video_on_out
   );

   modport slave (
      input  frame_start, video_on_in, pixel_row, pixel_column,
             loc_x, loc_y, bot_info,
      output icon, video_on_out
   );
endinterface

// File: rtl/bot_icon_gen_icon_rom.sv
// Combinational icon bitmap table: two 16x16 bitmaps of 2-bit codes.
//   base : 0 = cardinal (north-pointing) bitmap, 1 = diagonal (NE-pointing)
//   sr   : source row 0..15
//   sc   : source column 0..15
//   code : 2-bit pixel code (00 transparent)
// Each row is packed with column 0 in the two most significant bits.
module icon_rom (
   input  logic       base,
   input  logic [3:0] sr,
   input  logic [3:0] sc,
   output logic [1:0] code
);

   localparam logic [31:0] BMP_N [16] = '{
      32'h4003C002, 32'h000FF000, 32'h003FF800, 32'h00FFFF00,
      32'h03FAAFC0, 32'h0FEAABF0, 32'h3EAAAABC, 32'h02AAAA80,
      32'h02A55A80, 32'h02A55A80, 32'h02A55A80, 32'h02AAAA80,
      32'h02AAAA80, 32'h00000000, 32'h01000000, 32'h80000002
   };

   localparam logic [31:0] BMP_NE [16] = '{
      32'h000000FE, 32'h000003FC, 32'h00000FAC, 32'h0000FEA8,
      32'h0003FA90, 32'h000FE940, 32'h003E9400, 32'h00F95000,
      32'h03E54000, 32'h0F950000, 32'h3E540000, 32'h39400000,
      32'h25000000, 32'h10000000, 32'h00000000, 32'hC0000001
   };

   logic [31:0] row_bits;

   // Column c lives at bit offset 2*(15-c), which is {~c, 1'b0}
   always_comb begin
      row_bits = base ? BMP_NE[sr] : BMP_N[sr];
      code     = row_bits[{~sc, 1'b0} +: 2];
   end

endmodule

// File: rtl/bot_icon_gen.sv
// Rojobot icon generator.
// For each display pixel, decides whether it lies in the 16x16 icon window
// centred on the bot and returns the oriented bitmap code, else transparent.
// The bot pose is captured once per frame so the icon never tears.
// Ports:
//   clock : pixel clock
//   rst   : synchronous, active-high reset
//   bus   : bot_icon_gen_if slave (pixel/pose inputs, icon/video_on_out)
// Latency from pixel inputs to icon/video_on_out is two clocks.
module bot_icon_gen #(
   parameter int SCALE_SHIFT = rojobot_video_pkg::SCALE_SHIFT,
   parameter int ICON_SIZE   = rojobot_video_pkg::ICON_SIZE,
   parameter int WORLD_PIX   = rojobot_video_pkg::WORLD_PIX
) (
   input  logic         clock,
   input  logic         rst,
   bot_icon_gen_if.slave bus
);
   import rojobot_video_pkg::*;

   localparam logic signed [10:0] ICON_EDGE = 11'(ICON_SIZE);
   localparam logic signed [10:0] ICON_HALF = 11'(ICON_SIZE / 2);
   localparam logic        [10:0] WORLD_LIM = 11'(WORLD_PIX);

   // Frame-latched pose
   logic [6:0] pose_x_q, pose_x_d;
   logic [6:0] pose_y_q, pose_y_d;
   heading_e   hdg_q, hdg_d;

   // Stage 1
   logic       in_win_q, in_win_d;
   logic       base_q, base_d;
   logic [3:0] sr_q, sr_d;
   logic [3:0] sc_q, sc_d;
   logic       von1_q, von1_d;

   // Stage 2
   logic [1:0] icon_q, icon_d;
   logic       von2_q, von2_d;

   logic signed [10:0] x0, y0, dx, dy;
   logic [3:0]         lc, lr;
   logic [1:0]         rom_code;
   logic               unused_bits;

   assign unused_bits = ^{bus.loc_x[7], bus.loc_y[7], bus.bot_info[7:3]};

   icon_rom u_rom (
      .base (base_q),
      .sr   (sr_q),
      .sc   (sc_q),
      .code (rom_code)
   );

   // Window test and rotation use the currently latched pose, so a pixel
   // arriving alongside frame_start still sees the previous frame's pose.
   always_comb begin
      pose_x_d = pose_x_q;
      pose_y_d = pose_y_q;
      hdg_d    = hdg_q;
      if (bus.frame_start) begin
         pose_x_d = bus.loc_x[6:0];
         pose_y_d = bus.loc_y[6:0];
         hdg_d    = heading_e'(bus.bot_info[2:0]);
      end

      // Window origin may go negative near the left/top world edge
      x0 = $signed(11'(pose_x_q) << SCALE_SHIFT) - ICON_HALF;
      y0 = $signed(11'(pose_y_q) << SCALE_SHIFT) - ICON_HALF;
      dx = $signed({1'b0, bus.pixel_column}) - x0;
      dy = $signed({1'b0, bus.pixel_row}) - y0;
      lc = dx[3:0];
      lr = dy[3:0];

      in_win_d = (dx >= 0) && (dx < ICON_EDGE) &&
                 (dy >= 0) && (dy < ICON_EDGE) &&
                 ({1'b0, bus.pixel_column} < WORLD_LIM) &&
                 ({1'b0, bus.pixel_row} < WORLD_LIM);
      base_d   = hdg_q[0];
      von1_d   = bus.video_on_in;

      // Odd headings use the diagonal bitmap; hdg[2:1] counts clockwise
      // quarter-turns applied by reading the source bitmap rotated back.
      sr_d = lr;
      sc_d = lc;
      case (hdg_q[2:1])
         2'd0: begin sr_d = lr;  sc_d = lc;  end
         2'd1: begin sr_d = ~lc; sc_d = lr;  end
         2'd2: begin sr_d = ~lr; sc_d = ~lc; end
         2'd3: begin sr_d = lc;  sc_d = ~lr; end
      endcase

      icon_d = (in_win_q && von1_q) ? rom_code : ICON_TRANSPARENT;
      von2_d = von1_q;
   end

   // Reset clears the pose and flushes both pipeline stages
   always_ff @(posedge clock) begin
      if (rst) begin
         pose_x_q <= '0;
         pose_y_q <= '0;
         hdg_q    <= HDG_N;
         in_win_q <= 1'b0;
         base_q   <= 1'b0;
         sr_q     <= '0;
         sc_q     <= '0;
         von1_q   <= 1'b0;
         icon_q   <= ICON_TRANSPARENT;
         von2_q   <= 1'b0;
      end else begin
         pose_x_q <= pose_x_d;
         pose_y_q <= pose_y_d;
         hdg_q    <= hdg_d;
         in_win_q <= in_win_d;
         base_q   <= base_d;
         sr_q     <= sr_d;
         sc_q     <= sc_d;
         von1_q   <= von1_d;
         icon_q   <= icon_d;
         von2_q   <= von2_d;
      end
   end

   assign bus.icon         = icon_q;
   assign bus.video_on_out = von2_q;

endmodule

// File: tb/tb_bot_icon_gen.sv
// Testbench for bot_icon_gen.
// Drives directed and random pixel/pose sequences and compares icon and
// video_on_out, two clocks later, against a geometric reference model that
// works from world position, heading and the bitmap table.
module tb_bot_icon_gen;
   import rojobot_video_pkg::*;

   logic clock = 1'b0;
   logic rst   = 1'b1;

   bot_icon_gen_if bus ();

   bot_icon_gen dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   always #20 clock = ~clock;

   // Reference copy of the two bitmaps, column 0 in the top two bits
   localparam logic [31:0] REF_N [16] = '{
      32'h4003C002, 32'h000FF000, 32'h003FF800, 32'h00FFFF00,
      32'h03FAAFC0, 32'h0FEAABF0, 32'h3EAAAABC, 32'h02AAAA80,
      32'h02A55A80, 32'h02A55A80, 32'h02A55A80, 32'h02AAAA80,
      32'h02AAAA80, 32'h00000000, 32'h01000000, 32'h80000002
   };
   localparam logic [31:0] REF_NE [16] = '{
      32'h000000FE, 32'h000003FC, 32'h00000FAC, 32'h0000FEA8,
      32'h0003FA90, 32'h000FE940, 32'h003E9400, 32'h00F95000,
      32'h03E54000, 32'h0F950000, 32'h3E540000, 32'h39400000,
      32'h25000000, 32'h10000000, 32'h00000000, 32'hC0000001
   };

   typedef struct {
      logic [1:0] icon;
      logic       von;
   } expect_t;

   expect_t exp_q[$];
   int      compared   = 0;
   int      mismatched = 0;

   // Model pose as seen by the pixel being presented
   int m_x = 0;
   int m_y = 0;
   int m_h = 0;

   function automatic logic [1:0] romLookup(int base, int sr, int sc);
      logic [31:0] bits;
      bits = (base != 0) ? REF_NE[sr] : REF_N[sr];
      return 2'((bits >> (2 * (15 - sc))) & 32'd3);
   endfunction

   function automatic logic [1:0] modelIcon(int row, int col, logic von);
      int x0, y0, lc, lr, sr, sc, q;
      x0 = m_x * 4 - 8;
      y0 = m_y * 4 - 8;
      lc = col - x0;
      lr = row - y0;
      if (!von || col >= 512 || row >= 512 || lc < 0 || lc > 15 || lr < 0 || lr > 15)
         return 2'b00;
      q = m_h / 2;
      case (q)
         0:       begin sr = lr;      sc = lc;      end
         1:       begin sr = 15 - lc; sc = lr;      end
         2:       begin sr = 15 - lr; sc = 15 - lc; end
         default: begin sr = lc;      sc = 15 - lr; end
      endcase
      return romLookup(m_h % 2, sr, sc);
   endfunction

   task automatic checkOutput(string tag);
      expect_t e;
      if (exp_q.size() >= 2) begin
         e = exp_q.pop_front();
         compared += 2;
         assert (bus.icon === e.icon) else begin
            mismatched++;
            $error("[TB] FAIL %s icon: got %0d expected %0d", tag, bus.icon, e.icon);
         end
         assert (bus.video_on_out === e.von) else begin
            mismatched++;
            $error("[TB] FAIL %s video_on_out: got %0b expected %0b", tag, bus.video_on_out, e.von);
         end
      end
   endtask

   // Presents one pixel for one clock, records its expected result and
   // checks the result of the pixel presented one step earlier.
   task automatic applyStimulus(logic r, logic fs, logic von, int row, int col,
                                logic [7:0] lx, logic [7:0] ly, logic [7:0] info,
                                string tag);
      expect_t e;
      rst              = r;
      bus.frame_start  = fs;
      bus.video_on_in  = von;
      bus.pixel_row    = 10'(row);
      bus.pixel_column = 10'(col);
      bus.loc_x        = lx;
      bus.loc_y        = ly;
      bus.bot_info     = info;
      e.icon = r ? 2'b00 : modelIcon(row & 1023, col & 1023, von);
      e.von  = r ? 1'b0 : von;
      if (r) begin
         foreach (exp_q[i]) exp_q[i] = '{2'b00, 1'b0};
         m_x = 0; m_y = 0; m_h = 0;
      end else if (fs) begin
         m_x = int'(lx[6:0]);
         m_y = int'(ly[6:0]);
         m_h = int'(info[2:0]);
      end
      exp_q.push_back(e);
      @(posedge clock);
      @(negedge clock);
      checkOutput(tag);
   endtask

   // Pose update with no visible pixel
   task automatic latchPose(int lx, int ly, int hdg);
      applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 8'(lx), 8'(ly), 8'(hdg), "latch");
   endtask

   // Presents a pixel with the current pose and no frame_start
   task automatic pix(int row, int col, logic von, string tag);
      applyStimulus(1'b0, 1'b0, von, row, col, 8'd100, 8'd100, 8'h00, tag);
   endtask

   initial begin
      bus.frame_start  = 1'b0;
      bus.video_on_in  = 1'b0;
      bus.pixel_row    = '0;
      bus.pixel_column = '0;
      bus.loc_x        = '0;
      bus.loc_y        = '0;
      bus.bot_info     = '0;
      @(negedge clock);

      // Reset held with video active, frame_start and a bot in view
      for (int i = 0; i < 5; i++)
         applyStimulus(1'b1, 1'b1, 1'b1, 8 + i, 8 + i, 8'd4, 8'd4, 8'd0, "reset");
      // Pose is zero after reset, so (0..7,0..7) would show icon if not flushed
      for (int i = 0; i < 4; i++)
         pix(2, 2 + i, 1'b1, "post_reset");

      // Pose latch, then loc changes without a pulse
      latchPose(32, 32, 0);
      for (int i = 118; i <= 137; i++)
         pix(i, i, 1'b1, "latch_diag");
      pix(120, 120, 1'b1, "latch_corner");
      pix(120, 135, 1'b1, "latch_edge_c");
      pix(135, 120, 1'b1, "latch_edge_r");
      pix(400, 400, 1'b1, "latch_old_loc");

      // Rotation: local (lr=3, lc=5) under east and north-west headings
      latchPose(32, 32, 2);
      pix(123, 125, 1'b1, "rot_east");
      latchPose(32, 32, 7);
      pix(123, 125, 1'b1, "rot_nw");
      for (int h = 0; h < 8; h++) begin
         latchPose(32, 32, h);
         for (int k = 0; k < 6; k++)
            pix(120 + $urandom_range(0, 15), 120 + $urandom_range(0, 15), 1'b1, "rot_sweep");
      end

      // Clipping at the origin corner
      latchPose(0, 0, 0);
      for (int c = 0; c < 12; c++) pix(3, c, 1'b1, "clip_lo_col");
      for (int r = 0; r < 12; r++) pix(r, 3, 1'b1, "clip_lo_row");
      pix(1023, 2, 1'b1, "clip_lo_wrap");

      // Clipping at the far corner
      latchPose(127, 127, 0);
      for (int c = 496; c < 520; c++) pix(505, c, 1'b1, "clip_hi_col");
      for (int r = 496; r < 520; r++) pix(r, 505, 1'b1, "clip_hi_row");

      // Blanking inside the window
      latchPose(32, 32, 0);
      pix(125, 125, 1'b0, "blank");
      pix(125, 125, 1'b1, "unblank");
      pix(121, 124, 1'b0, "blank2");

      // frame_start on an in-window pixel: old pose for it, new pose next
      applyStimulus(1'b0, 1'b1, 1'b1, 125, 125, 8'd80, 8'd80, 8'd4, "fs_same_cycle");
      pix(125, 125, 1'b1, "fs_next_old");
      pix(318, 318, 1'b1, "fs_next_new");

      // Random traffic near the bot with occasional pose changes and a reset
      for (int i = 0; i < 400; i++) begin
         logic       fs, von, r;
         logic [7:0] lx, ly, info;
         int         row, col;
         fs   = ($urandom_range(0, 15) == 0);
         r    = (i == 200);
         von  = ($urandom_range(0, 7) != 0);
         lx   = 8'($urandom);
         ly   = 8'($urandom);
         info = 8'($urandom);
         row  = m_y * 4 - 10 + $urandom_range(0, 20);
         col  = m_x * 4 - 10 + $urandom_range(0, 20);
         if ($urandom_range(0, 9) == 0) col = $urandom_range(0, 1023);
         applyStimulus(r, fs, von, row, col, lx, ly, info, "random");
      end

      // Drain the pipeline
      pix(0, 1000, 1'b0, "drain");
      pix(0, 1000, 1'b0, "drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
